// File: rtl/comb_dereverb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comb_dereverb_if : sample handshake bundle for comb_dereverb          |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface comb_dereverb_if #(
    parameter int DATA_BITS = 16
);
    logic                 enable;
    logic [7:0]           reverb_alpha;
    logic [DATA_BITS-1:0] din;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 busy;

    modport master (
        output enable, reverb_alpha, din,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  enable, reverb_alpha, din,
        output dout, dout_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/comb_dereverb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comb_dereverb : inverse feedback comb, dout = din - (alpha*dout[n-D])>>8 |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module comb_dereverb #(
    parameter int DATA_BITS    = 16,
    parameter int DELAY_LENGTH = 1024
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    comb_dereverb_if.slave  bus
);
    localparam int PTR_BITS  = $clog2(DELAY_LENGTH);
    localparam int PROD_BITS = DATA_BITS + 8;
    localparam logic [PTR_BITS:0] FILL_FULL = (PTR_BITS+1)'(DELAY_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_MULT = 2'd2,
        S_SUB  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   din_q;
    logic [7:0]             alpha_q;
    logic [PTR_BITS-1:0]    wr_ptr_q;
    logic [PTR_BITS:0]      fill_q;
    logic [DATA_BITS-1:0]   ram_rd_q;
    logic [DATA_BITS-1:0]   delayed_q;
    logic [PROD_BITS-1:0]   prod_q;
    logic [DATA_BITS-1:0]   dout_q;
    logic                   dout_valid_q;

    logic [DATA_BITS-1:0]   history [0:DELAY_LENGTH-1];

    logic                   accept;
    logic                   ram_we;
    logic [DATA_BITS-1:0]   result;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_MULT;
            S_MULT:  state_d = S_SUB;
            S_SUB: begin
                ram_we  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result = din_q - prod_q[PROD_BITS-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // History RAM is never cleared; the fill counter keeps stale data out.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            history[wr_ptr_q] <= result;
        end
        if (accept) begin
            ram_rd_q <= history[wr_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q        <= '0;
            alpha_q      <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            delayed_q    <= '0;
            prod_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        din_q   <= bus.din;
                        alpha_q <= bus.reverb_alpha;
                    end
                end
                S_READ: begin
                    delayed_q <= (fill_q == FILL_FULL) ? ram_rd_q : '0;
                end
                S_MULT: begin
                    prod_q <= PROD_BITS'(alpha_q) * PROD_BITS'(delayed_q);
                end
                S_SUB: begin
                    dout_q       <= result;
                    dout_valid_q <= 1'b1;
                    wr_ptr_q     <= wr_ptr_q + PTR_BITS'(1);
                    if (fill_q != FILL_FULL) begin
                        fill_q <= fill_q + (PTR_BITS+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_comb_dereverb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comb_dereverb : directed vector bench for comb_dereverb            |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_comb_dereverb;
    localparam int NRT = 5000;

    typedef struct {
        bit          rst;
        logic [15:0] din;
        logic [7:0]  alpha;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    comb_dereverb_if #(.DATA_BITS(16)) i4  ();
    comb_dereverb_if #(.DATA_BITS(16)) i1k ();

    comb_dereverb #(.DATA_BITS(16), .DELAY_LENGTH(4)) dut_short (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i4.slave)
    );

    comb_dereverb #(.DATA_BITS(16), .DELAY_LENGTH(1024)) dut_long (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i1k.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk("rst_dout", {16'd0, i4.dout}, 32'd0);
        chk("rst_valid", {31'd0, i4.dout_valid}, 32'd0);
        chk("rst_busy", {31'd0, i4.busy}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] d, input logic [7:0] a,
                         input logic [15:0] exp, input string name);
        int lat;
        i4.enable       = 1'b1;
        i4.din          = d;
        i4.reverb_alpha = a;
        @(posedge clk);
        #1;
        i4.enable = 1'b0;
        chk({name, "_busy"}, {31'd0, i4.busy}, 32'd1);
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (i4.dout_valid) break;
        end
        chk({name, "_lat"}, lat, 3);
        chk({name, "_dout"}, {16'd0, i4.dout}, {16'd0, exp});
        chk({name, "_idle"}, {31'd0, i4.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_pulse"}, {31'd0, i4.dout_valid}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t        vecs [14];
    logic [15:0] xs   [NRT];
    logic [15:0] y;
    int          nvalid;
    int          lat;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        i4.enable = 1'b0;  i4.din = '0;  i4.reverb_alpha = '0;
        i1k.enable = 1'b0; i1k.din = '0; i1k.reverb_alpha = '0;

        // Impulse response with a 4-sample echo, then fill gating.
        vecs[0]  = '{1'b1, 16'd1000, 8'd128, 16'd1000};
        vecs[1]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[2]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[3]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[4]  = '{1'b0, 16'd0,    8'd128, 16'd65036};
        vecs[5]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[6]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[7]  = '{1'b0, 16'd0,    8'd128, 16'd0};
        vecs[8]  = '{1'b0, 16'd0,    8'd128, 16'd33018};
        vecs[9]  = '{1'b1, 16'd100,  8'd255, 16'd100};
        vecs[10] = '{1'b0, 16'd100,  8'd255, 16'd100};
        vecs[11] = '{1'b0, 16'd100,  8'd255, 16'd100};
        vecs[12] = '{1'b0, 16'd100,  8'd255, 16'd100};
        vecs[13] = '{1'b0, 16'd100,  8'd255, 16'd1};

        // Reset values and an idle stretch with no output strobe.
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        nvalid = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (i4.dout_valid || i1k.dout_valid) nvalid++;
        end
        chk("idle_no_valid", nvalid, 0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            send4(vecs[i].din, vecs[i].alpha, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Enable held for 4 cycles: only the first sample is taken,
        // and a new sample is taken right at k+4.
        do_reset();
        i4.reverb_alpha = 8'd0;
        i4.enable = 1'b1;
        i4.din    = 16'd7;
        nvalid    = 0;
        @(posedge clk); #1; i4.din = 16'd8;  if (i4.dout_valid) nvalid++;
        @(posedge clk); #1; i4.din = 16'd9;  if (i4.dout_valid) nvalid++;
        @(posedge clk); #1; i4.din = 16'd10; if (i4.dout_valid) nvalid++;
        chk("drop_early_valid", nvalid, 0);
        @(posedge clk); #1;
        chk("drop_valid", {31'd0, i4.dout_valid}, 32'd1);
        chk("drop_dout", {16'd0, i4.dout}, 32'd7);
        i4.din = 16'd11;
        @(posedge clk); #1;
        i4.enable = 1'b0;
        chk("drop_reaccept_busy", {31'd0, i4.busy}, 32'd1);
        nvalid = 0;
        @(posedge clk); #1; if (i4.dout_valid) nvalid++;
        @(posedge clk); #1; if (i4.dout_valid) nvalid++;
        chk("drop_single_valid", nvalid, 0);
        @(posedge clk); #1;
        chk("drop_next_valid", {31'd0, i4.dout_valid}, 32'd1);
        chk("drop_next_dout", {16'd0, i4.dout}, 32'd11);
        repeat (4) @(posedge clk);
        #1;

        // Reset asserted while a sample sits in MULT.
        do_reset();
        send4(16'd500, 8'd128, 16'd500, "pre0");
        send4(16'd600, 8'd128, 16'd600, "pre1");
        i4.enable = 1'b1; i4.din = 16'd700; i4.reverb_alpha = 8'd128;
        @(posedge clk); #1;
        i4.enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("mid_busy", {31'd0, i4.busy}, 32'd0);
        chk("mid_dout", {16'd0, i4.dout}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        nvalid = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (i4.dout_valid) nvalid++;
        end
        chk("mid_no_valid", nvalid, 0);
        send4(16'd10, 8'd255, 16'd10, "post0");
        send4(16'd20, 8'd255, 16'd20, "post1");
        send4(16'd30, 8'd255, 16'd30, "post2");
        send4(16'd40, 8'd255, 16'd40, "post3");
        send4(16'd0,  8'd255, 16'd65527, "post4");

        // Round trip through a feedforward reverb model, 1024-sample echo.
        do_reset();
        for (int n = 0; n < NRT; n++) begin
            xs[n] = 16'($urandom);
            if (n < 1024) y = xs[n];
            else          y = xs[n] + 16'((32'd200 * {16'd0, xs[n-1024]}) >> 8);
            i1k.enable       = 1'b1;
            i1k.din          = y;
            i1k.reverb_alpha = 8'd200;
            @(posedge clk); #1;
            i1k.enable = 1'b0;
            lat = 0;
            while (lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
                if (i1k.dout_valid) break;
            end
            chk($sformatf("rt%0d_lat", n), lat, 3);
            chk($sformatf("rt%0d_dout", n), {16'd0, i1k.dout}, {16'd0, xs[n]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/comb_dereverb.md
# comb_dereverb

Inverse feedback-comb filter that removes the single-tap echo added by the team's feedforward comb reverb. Each accepted sample computes dout[n] = din[n] − ((alpha · dout[n−DELAY_LENGTH]) >> 8) mod 2^DATA_BITS, using a circular-buffer RAM of past outputs. With matching DATA_BITS, DELAY_LENGTH and alpha, it exactly undoes the reverb stage. It sits after the reverb in the sound test chain and also serves as a loopback check of that stage.

## Interface
- DATA_BITS, 16, sample width; unsigned, wrap-around arithmetic
- DELAY_LENGTH, 1024, echo delay in accepted samples; power of two, ≥ 2
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  sample strobe; sampled only when busy = 0
- reverb_alpha  input  8  echo weight in 1/256 units; latched on accept
- din  input  DATA_BITS  reverberated input sample; latched on accept
- dout  output  DATA_BITS  de-reverberated sample; holds its value between updates
- dout_valid  output  1  one-cycle pulse when dout updates
- busy  output  1  high while a sample is in flight

## Operation
- Storage: RAM history[0:DELAY_LENGTH−1] of DATA_BITS, synchronous read, one write port. Write pointer wr_ptr has log2(DELAY_LENGTH) bits and wraps from DELAY_LENGTH−1 to 0.
- fill counter: counts from 0 to DELAY_LENGTH and saturates there. While fill < DELAY_LENGTH, the delayed sample is forced to 0. RAM contents are never cleared; no X or stale data reaches dout.
- FSM: IDLE → READ → MULT → SUB → IDLE.
  - IDLE: on enable = 1, latch din and reverb_alpha, issue RAM read at wr_ptr (the oldest entry, sample n−DELAY_LENGTH), go to READ.
  - READ: register the RAM data, or 0 if not yet filled.
  - MULT: register prod = alpha_q × delayed, a DATA_BITS+8-bit product.
  - SUB: result = din_q − prod[DATA_BITS+7:8], truncated to DATA_BITS (mod 2^DATA_BITS).
    - Register result into dout and pulse dout_valid.
    - Write history[wr_ptr] = result.
    - Increment wr_ptr with wrap; increment fill if not saturated.
    - Return to IDLE.
- enable while busy = 1 is ignored; the sample is dropped. No queueing.
- alpha = 0 gives a pure pass-through, except for the latency.
- Reset, asynchronous, also mid-operation:
  - FSM → IDLE; wr_ptr = 0; fill = 0.
  - dout = 0; dout_valid = 0; busy = 0.
  - An in-flight sample is discarded and writes nothing.

## Timing
- Accept at edge k (IDLE, enable = 1).
  - busy = 1 after edge k, through edge k+3.
  - dout and dout_valid update at edge k+3; dout_valid is high for exactly the one cycle following edge k+3.
  - busy = 0 after edge k+3.
- Next accept is possible at edge k+4, so the maximum rate is one sample per 4 clocks.
- RAM write occurs at edge k+3. A read of the same slot DELAY_LENGTH samples later sees the written value; the earliest same-address read is at edge k+4, so there is no read-during-write hazard.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: hold rst_n = 0 → dout = 0, dout_valid = 0, busy = 0. Release, idle 10 cycles → no dout_valid.
- Impulse (DELAY_LENGTH = 4, alpha = 128, enable every 8 clocks): din = 1000 then zeros → dout = 1000, 0, 0, 0, 65036, 0, 0, 0, 33018. Each dout_valid arrives 3 edges after its accept.
- Fill gating (DELAY_LENGTH = 4, alpha = 255): din = 100 constant → first 4 outputs = 100, fifth output = 1. No X on dout at any point.
- Busy drop: assert enable on 4 consecutive cycles with din = 7, 8, 9, 10 → only din = 7 processed (dout = 7, one dout_valid); the next valid sample is accepted at edge k+4.
- Round trip (DELAY_LENGTH = 1024, alpha = 200): feed the reverb stage's output with 5000 random samples → dout equals the original din sequence bit-exactly, including wrap-around cases.
- Mid-operation reset: drop rst_n during MULT → no dout_valid; after release, wr_ptr = 0 and fill = 0, so the next DELAY_LENGTH outputs equal din.
